// File: rtl/dff_ontransit_pkg.sv
// Shared definitions for the registered-on-transition run framers.
// Holds the controller state encoding and a width helper.
package dff_ontransit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    // Bits needed to hold values 0..v-1 (minimum 1 bit).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/dff_ontransit_cnt.sv
// Run framer: tracks runs of the run-request input and emits continue,
// end-of-run and overflow pulses plus the captured run length. Every
// output is registered together with the state, so it appears one cycle
// after the cycle that caused it. A programmable LAST gap guarantees idle
// cycles between runs.
// The run-request input is named do_req because "do" is a reserved word.
import dff_ontransit_pkg::*;

module dff_ontransit_cnt #(
    parameter int CNT_W   = 8,
    parameter int MAX_LEN = 200,
    parameter int GAP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             do_req,
    output logic             g,
    output logic             s,
    output logic             ovf,
    output logic [CNT_W-1:0] len,
    output logic             busy
);

    localparam int GCW = clog2(GAP + 1);
    localparam logic [CNT_W-1:0] MAXV    = CNT_W'(MAX_LEN);
    localparam logic [GCW-1:0]   GAP_END = GCW'(GAP - 1);

    if (MAX_LEN < 1 || MAX_LEN > (2 ** CNT_W) - 1) begin : g_bad_max_len
        $error("dff_ontransit_cnt: MAX_LEN out of range 1..2^CNT_W-1");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("dff_ontransit_cnt: GAP must be at least 1");
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [GCW-1:0]   gcnt, gcnt_nx;
    logic             nx_g, nx_s, nx_ovf, nx_busy;
    logic [CNT_W-1:0] nx_len;

    // Next state, counters and the values every output will register.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gcnt_nx  = gcnt;
        nx_g     = 1'b0;
        nx_s     = 1'b0;
        nx_ovf   = 1'b0;
        nx_len   = len;
        case (state)
            IDLE: begin
                if (do_req) begin
                    state_nx = RUN;
                    cnt_nx   = CNT_W'(1);
                end
            end
            RUN: begin
                if (do_req && cnt < MAXV) begin
                    cnt_nx = cnt + CNT_W'(1);
                    nx_s   = 1'b1;
                end else begin
                    // Run ended either by do_req dropping or by hitting
                    // MAX_LEN; in the latter case cnt already equals MAXV.
                    state_nx = LAST;
                    nx_g     = 1'b1;
                    nx_ovf   = do_req;
                    nx_len   = cnt;
                    gcnt_nx  = '0;
                end
            end
            LAST: begin
                if (gcnt == GAP_END) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    gcnt_nx  = '0;
                end else begin
                    gcnt_nx = gcnt + GCW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                gcnt_nx  = '0;
            end
        endcase
        nx_busy = (state_nx != IDLE);
    end

    // State, counters and outputs all update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            gcnt  <= '0;
            g     <= 1'b0;
            s     <= 1'b0;
            ovf   <= 1'b0;
            len   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            gcnt  <= gcnt_nx;
            g     <= nx_g;
            s     <= nx_s;
            ovf   <= nx_ovf;
            len   <= nx_len;
            busy  <= nx_busy;
        end
    end

`ifndef SYNTHESIS
    // Readable state name for waveform viewers and debug prints.
    function automatic string state_name(input state_t st);
        case (st)
            IDLE:    return "IDLE";
            RUN:     return "RUN";
            LAST:    return "LAST";
            default: return "ILLEGAL";
        endcase
    endfunction
`endif

endmodule

// File: tb/tb_dff_ontransit_cnt.sv
// Bench for dff_ontransit_cnt: three instances with different parameters
// share one stimulus stream; a run/gap-counting model predicts every
// output each cycle, and literal expectations pin key scenario results.
module tb_dff_ontransit_cnt;

    logic clk = 1'b0;
    logic rst;
    logic d;

    logic       dg[3], dsv[3], dov[3], dbusy[3];
    logic [7:0] len_a, len_b;
    logic [3:0] len_c;

    // configs: 0 = default, 1 = short max with long gap, 2 = narrow counter
    int MX[3] = '{200, 4, 15};
    int GP[3] = '{2, 3, 2};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dff_ontransit_cnt #(.CNT_W(8), .MAX_LEN(200), .GAP(2)) u_a (
        .clk(clk), .rst(rst), .do_req(d), .g(dg[0]), .s(dsv[0]),
        .ovf(dov[0]), .len(len_a), .busy(dbusy[0]));
    dff_ontransit_cnt #(.CNT_W(8), .MAX_LEN(4), .GAP(3)) u_b (
        .clk(clk), .rst(rst), .do_req(d), .g(dg[1]), .s(dsv[1]),
        .ovf(dov[1]), .len(len_b), .busy(dbusy[1]));
    dff_ontransit_cnt #(.CNT_W(4), .MAX_LEN(15), .GAP(2)) u_c (
        .clk(clk), .rst(rst), .do_req(d), .g(dg[2]), .s(dsv[2]),
        .ovf(dov[2]), .len(len_c), .busy(dbusy[2]));

    function automatic int dlen(input int i);
        case (i)
            0:       return int'(len_a);
            1:       return int'(len_b);
            default: return int'(len_c);
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // run = cycles of do seen so far in the current run (0 = not running),
    // gap = LAST cycles still to spend before requests are accepted again.
    int m_run[3]  = '{0, 0, 0};
    int m_gap[3]  = '{0, 0, 0};
    int m_len[3]  = '{0, 0, 0};
    bit m_g[3]    = '{0, 0, 0};
    bit m_s[3]    = '{0, 0, 0};
    bit m_ovf[3]  = '{0, 0, 0};
    bit m_busy[3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int r, gp, l;
            bit pg, ps, po;
            r = m_run[i]; gp = m_gap[i]; l = m_len[i];
            pg = 0; ps = 0; po = 0;
            if (rst) begin
                r = 0; gp = 0; l = 0;
            end else if (gp > 0) begin
                gp = gp - 1;
            end else if (r > 0) begin
                if (d && r < MX[i]) begin
                    r = r + 1; ps = 1;
                end else begin
                    pg = 1; po = d; l = r; r = 0; gp = GP[i];
                end
            end else if (d) begin
                r = 1;
            end
            m_run[i]  <= r;
            m_gap[i]  <= gp;
            m_len[i]  <= l;
            m_g[i]    <= pg;
            m_s[i]    <= ps;
            m_ovf[i]  <= po;
            m_busy[i] <= (r > 0) || (gp > 0);
        end
    end

    task automatic chk(input string nm, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0d want=%0d at %0t", nm, i, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare + pulse tallies ----------------
    int sc[3] = '{0, 0, 0};
    int gc[3] = '{0, 0, 0};
    int oc[3] = '{0, 0, 0};
    int bc[3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("g",    i, int'(dg[i]),    int'(m_g[i]));
            chk("s",    i, int'(dsv[i]),   int'(m_s[i]));
            chk("ovf",  i, int'(dov[i]),   int'(m_ovf[i]));
            chk("busy", i, int'(dbusy[i]), int'(m_busy[i]));
            chk("len",  i, dlen(i),        m_len[i]);
            sc[i] += int'(dsv[i]);
            gc[i] += int'(dg[i]);
            oc[i] += int'(dov[i]);
            bc[i] += int'(dbusy[i]);
        end
    end

    // ---------------- stimulus ----------------
    int s_b[3], g_b[3], o_b[3], b_b[3];

    task automatic snap();
        for (int i = 0; i < 3; i++) begin
            s_b[i] = sc[i]; g_b[i] = gc[i]; o_b[i] = oc[i]; b_b[i] = bc[i];
        end
    endtask

    // Drive one cycle; returns just after the following falling edge.
    task automatic tick(input bit dv, input bit rv);
        d = dv; rst = rv;
        @(negedge clk);
        #1;
    endtask

    // Literal expectations on one instance (DUT and model both pinned).
    task automatic pin(input string nm, input int i, input int exp_len,
                       input int exp_s, input int exp_g, input int exp_o);
        chk({nm, "_len"},  i, dlen(i), exp_len);
        chk({nm, "_mlen"}, i, m_len[i], exp_len);
        chk({nm, "_scnt"}, i, sc[i] - s_b[i], exp_s);
        chk({nm, "_gcnt"}, i, gc[i] - g_b[i], exp_g);
        chk({nm, "_ocnt"}, i, oc[i] - o_b[i], exp_o);
    endtask

    initial begin
        int lvl;
        d = 1'b1; rst = 1'b1;

        // reset held with do high
        repeat (3) tick(1, 1);
        for (int i = 0; i < 3; i++) begin
            chk("rst_len",  i, dlen(i), 0);
            chk("rst_busy", i, int'(dbusy[i]), 0);
        end
        snap();

        // normal run of 5 (instance 1 overflows at 4)
        tick(1, 0);
        chk("first_idle_starts", 0, int'(dbusy[0]), 1);
        repeat (4) tick(1, 0);
        repeat (8) tick(0, 0);
        pin("run5", 0, 5, 4, 1, 0);
        chk("run5_busycnt", 0, bc[0] - b_b[0], 7);
        pin("run5", 1, 4, 3, 1, 1);
        pin("run5", 2, 5, 4, 1, 0);

        // long request: overflow and restart on instance 1
        snap();
        repeat (10) tick(1, 0);
        repeat (10) tick(0, 0);
        pin("run10", 0, 10, 9, 1, 0);
        pin("run10", 1, 2, 4, 2, 1);
        pin("run10", 2, 10, 9, 1, 0);

        // toggling do: 1-cycle runs, requests during LAST ignored
        snap();
        for (int k = 0; k < 16; k++) tick((k % 2) == 0, 0);
        repeat (8) tick(0, 0);
        pin("tog", 0, 1, 0, 4, 0);
        pin("tog", 1, 1, 0, 3, 0);

        // reset during the third RUN cycle
        snap();
        repeat (3) tick(1, 0);
        tick(1, 1);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_len",  i, dlen(i), 0);
            chk("midrst_busy", i, int'(dbusy[i]), 0);
            chk("midrst_g",    i, gc[i] - g_b[i], 0);
            chk("midrst_ovf",  i, oc[i] - o_b[i], 0);
        end
        repeat (2) tick(0, 0);

        // counter width boundary on instance 2
        snap();
        repeat (17) tick(1, 0);
        repeat (8) tick(0, 0);
        pin("wide", 2, 15, 14, 1, 1);
        pin("wide", 0, 17, 16, 1, 0);

        // randomized traffic with occasional resets
        lvl = 5;
        for (int k = 0; k < 3000; k++) begin
            if (k % 50 == 0) lvl = $urandom_range(0, 10);
            tick($urandom_range(0, 9) < lvl, $urandom_range(0, 199) == 0);
        end
        repeat (6) tick(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
